// File: rtl/clock_divider.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// clock_divider
//
// Integer clock divider. It produces a free-running square wave clk_N with a
// period of N input clocks and 50% duty cycle, for both even and odd N.
//
// Parameters:
//   N      division ratio (output period in clk cycles), integer >= 1.
//          N = 0 is rejected at elaboration.
//
// Ports:
//   clk    input clock. All state advances on its rising edge, except one
//          falling-edge register that exists only for odd N >= 3.
//   rst_n  asynchronous active-low reset. clk_N is held at 0 while it is low.
//   clk_N  divided clock. It is registered for N > 1 and is clk gated with
//          rst_n for N = 1. Treat it as a generated clock downstream.
//   tick   (only when CLK_DIV_TICK_EN is defined) one-clk-wide enable pulse,
//          registered on posedge clk, high in the cycle where the counter
//          has just wrapped to 0. It lets synchronous logic use a clock
//          enable instead of clk_N. For N = 1 it is constantly 1 after reset.
//
// Optional feature macro: CLK_DIV_TICK_EN (adds the tick port and its logic).
// -----------------------------------------------------------------------------
module clock_divider #(
  parameter int N = 10000
) (
  input  logic clk,
  input  logic rst_n,
  output logic clk_N
`ifdef CLK_DIV_TICK_EN
  ,
  output logic tick
`endif
);

  // Counter width: enough bits to hold N-1, never less than one bit.
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  if (N < 1) begin : g_bad_n
    $error("clock_divider: N must be at least 1");
  end

  if (N == 1) begin : g_pass
    // Divide-by-one: the only case with a combinational path from clk.
    // Gating with rst_n keeps the output low during reset.
    assign clk_N = clk & rst_n;

`ifdef CLK_DIV_TICK_EN
    logic tick_r;

    // Enable is permanently asserted once out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        tick_r <= 1'b0;
      end else begin
        tick_r <= 1'b1;
      end
    end

    assign tick = tick_r;
`endif
  end else begin : g_div
    // Last count before wrapping, and the count at which the output goes high.
    // (N+1)/2 equals N/2 for even N, so one expression covers both parities.
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] HALF_C = CNT_W'((N + 1) / 2);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] next_cnt_s;
    logic             p_r;

    // Next counter value: wrap to zero after N-1 with no idle cycle.
    always_comb begin
      next_cnt_s = {CNT_W{1'b0}};
      if (cnt_r == LAST_C) begin
        next_cnt_s = {CNT_W{1'b0}};
      end else begin
        next_cnt_s = cnt_r + CNT_W'(1);
      end
    end

    // Period counter and the rising-edge half of the output waveform.
    // p_r is high while the count sits in the upper half of the period.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_r <= {CNT_W{1'b0}};
        p_r   <= 1'b0;
      end else begin
        cnt_r <= next_cnt_s;
        p_r   <= (next_cnt_s >= HALF_C);
      end
    end

    if ((N % 2) == 1) begin : g_odd
      // For odd N the high phase must be N/2 clk periods (a half-cycle
      // fraction). q_r is p_r delayed by half a clk period; ORing the two
      // stretches the high phase by half a cycle. q_r only rises while p_r
      // is already high and p_r only falls while q_r is still high, so the
      // OR never sees two simultaneous transitions and cannot glitch.
      logic q_r;

      // Half-cycle delayed copy of p_r, captured on the falling clk edge.
      always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q_r <= 1'b0;
        end else begin
          q_r <= p_r;
        end
      end

      assign clk_N = p_r | q_r;
    end else begin : g_even
      assign clk_N = p_r;
    end

`ifdef CLK_DIV_TICK_EN
    logic tick_r;

    // One-cycle enable in the cycle where the counter has just wrapped to 0.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        tick_r <= 1'b0;
      end else begin
        tick_r <= (next_cnt_s == {CNT_W{1'b0}});
      end
    end

    assign tick = tick_r;
`endif
  end

endmodule

// File: tb/tb_clock_divider.sv
`timescale 1ns/1ps
module tb_clock_divider;

  logic clk;
  logic rst_n;
  logic cn4, cn3, cn1, cn10k, cn8, cn5;
`ifdef CLK_DIV_TICK_EN
  logic tk4, tk3, tk1, tk10k, tk8, tk5;
`endif

  int n_cmp;
  int n_err;

  clock_divider #(.N(4)) u_n4 (.clk(clk), .rst_n(rst_n), .clk_N(cn4)
`ifdef CLK_DIV_TICK_EN
    , .tick(tk4)
`endif
  );
  clock_divider #(.N(3)) u_n3 (.clk(clk), .rst_n(rst_n), .clk_N(cn3)
`ifdef CLK_DIV_TICK_EN
    , .tick(tk3)
`endif
  );
  clock_divider #(.N(1)) u_n1 (.clk(clk), .rst_n(rst_n), .clk_N(cn1)
`ifdef CLK_DIV_TICK_EN
    , .tick(tk1)
`endif
  );
  clock_divider u_n10k (.clk(clk), .rst_n(rst_n), .clk_N(cn10k)
`ifdef CLK_DIV_TICK_EN
    , .tick(tk10k)
`endif
  );
  clock_divider #(.N(8)) u_n8 (.clk(clk), .rst_n(rst_n), .clk_N(cn8)
`ifdef CLK_DIV_TICK_EN
    , .tick(tk8)
`endif
  );
  clock_divider #(.N(5)) u_n5 (.clk(clk), .rst_n(rst_n), .clk_N(cn5)
`ifdef CLK_DIV_TICK_EN
    , .tick(tk5)
`endif
  );

  // 10 ns input clock period, first posedge at 5 ns.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hold reset for a few cycles, then release between edges so the next
  // posedge is posedge 1 after release.
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({cn4, cn3, cn1, cn10k, cn8, cn5} !== 6'b000000) begin
      n_err++;
      $display("FAIL reset_async: outputs=%b want 000000", {cn4, cn3, cn1, cn10k, cn8, cn5});
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({cn4, cn3, cn1, cn10k, cn8, cn5} !== 6'b000000) begin
        n_err++;
        $display("FAIL reset_pos%0d: outputs=%b want 000000", i, {cn4, cn3, cn1, cn10k, cn8, cn5});
      end
      @(negedge clk); #1;
      n_cmp++;
      if ({cn4, cn3, cn1, cn10k, cn8, cn5} !== 6'b000000) begin
        n_err++;
        $display("FAIL reset_neg%0d: outputs=%b want 000000", i, {cn4, cn3, cn1, cn10k, cn8, cn5});
      end
    end
  endtask

  task automatic test_even_n4();
    logic exp;
    do_reset();
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      exp = ((k % 4) >= 2);
      n_cmp++;
      if (cn4 !== exp) begin
        n_err++;
        $display("FAIL n4_pos%0d: clk_N=%b want %b", k, cn4, exp);
      end
    end
  endtask

  task automatic test_odd_n3();
    logic exp;
    int c;
    do_reset();
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      c = k % 3;
      // Right after the wrap to 0 the delayed copy still holds the output high.
      exp = (c >= 2) || (c == 0);
      n_cmp++;
      if (cn3 !== exp) begin
        n_err++;
        $display("FAIL n3_pos%0d: clk_N=%b want %b", k, cn3, exp);
      end
      @(negedge clk); #1;
      exp = (c >= 2);
      n_cmp++;
      if (cn3 !== exp) begin
        n_err++;
        $display("FAIL n3_neg%0d: clk_N=%b want %b", k, cn3, exp);
      end
    end
  endtask

  task automatic test_n1();
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (cn1 !== 1'b1) begin
        n_err++;
        $display("FAIL n1_pos%0d: clk_N=%b want 1", k, cn1);
      end
      @(negedge clk); #1;
      n_cmp++;
      if (cn1 !== 1'b0) begin
        n_err++;
        $display("FAIL n1_neg%0d: clk_N=%b want 0", k, cn1);
      end
    end
  endtask

  task automatic test_default_n10000();
    int rise1, rise2, fall1;
    logic prev;
    rise1 = -1;
    rise2 = -1;
    fall1 = -1;
    prev  = 1'b0;
    do_reset();
    for (int k = 1; k <= 15010; k++) begin
      @(posedge clk); #1;
      if (cn10k === 1'b1 && prev === 1'b0) begin
        if (rise1 < 0) begin
          rise1 = k;
        end else if (rise2 < 0) begin
          rise2 = k;
        end
      end
      if (cn10k === 1'b0 && prev === 1'b1 && fall1 < 0) begin
        fall1 = k;
      end
      prev = cn10k;
    end
    n_cmp++;
    if (rise1 != 5000) begin
      n_err++;
      $display("FAIL n10k_first_rise: posedge %0d want 5000", rise1);
    end
    n_cmp++;
    if (fall1 != 10000) begin
      n_err++;
      $display("FAIL n10k_first_fall: posedge %0d want 10000", fall1);
    end
    n_cmp++;
    if ((rise2 - rise1) != 10000 || rise2 < 0) begin
      n_err++;
      $display("FAIL n10k_period: %0d clk want 10000", rise2 - rise1);
    end
    n_cmp++;
    if ((fall1 - rise1) != 5000 || fall1 < 0) begin
      n_err++;
      $display("FAIL n10k_high_time: %0d clk want 5000", fall1 - rise1);
    end
  endtask

  task automatic test_reset_mid_high();
    logic exp;
    do_reset();
    repeat (6) @(posedge clk);
    #1;
    n_cmp++;
    if (cn8 !== 1'b1) begin
      n_err++;
      $display("FAIL n8_high_before_reset: clk_N=%b want 1", cn8);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (cn8 !== 1'b0) begin
      n_err++;
      $display("FAIL n8_async_low: clk_N=%b want 0", cn8);
    end
    n_cmp++;
    if (cn1 !== 1'b0) begin
      n_err++;
      $display("FAIL n1_async_low: clk_N=%b want 0", cn1);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      exp = ((k % 8) >= 4);
      n_cmp++;
      if (cn8 !== exp) begin
        n_err++;
        $display("FAIL n8_restart_pos%0d: clk_N=%b want %b", k, cn8, exp);
      end
    end
  endtask

`ifdef CLK_DIV_TICK_EN
  task automatic test_tick();
    logic exp;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (tk5 !== 1'b0 || tk1 !== 1'b0) begin
        n_err++;
        $display("FAIL tick_reset%0d: tick5=%b tick1=%b want 0 0", i, tk5, tk1);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      exp = ((k % 5) == 0);
      n_cmp++;
      if (tk5 !== exp) begin
        n_err++;
        $display("FAIL tick5_pos%0d: tick=%b want %b", k, tk5, exp);
      end
      n_cmp++;
      if (tk1 !== 1'b1) begin
        n_err++;
        $display("FAIL tick1_pos%0d: tick=%b want 1", k, tk1);
      end
    end
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    test_reset();
    test_even_n4();
    test_odd_n3();
    test_n1();
    test_default_n10000();
    test_reset_mid_high();
`ifdef CLK_DIV_TICK_EN
    test_tick();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
